// File: rtl/cond_logic_unit_pkg.sv
// Shared condition encodings and NZCV / FlagW bit positions for the condition stage.
// Optional COND_SKIP_CNT_EN build adds a squash counter; nothing here depends on it.
package cpu_cond_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FW_NZ = 1;
    localparam int FW_CV = 0;

endpackage

// File: rtl/cond_logic_unit_if.sv
// Decoder/ALU-to-condition-stage bundle; master drives the instruction side, slave is the stage.
// SkipCnt exists only when COND_SKIP_CNT_EN is defined.
interface cond_logic_unit_if #(
    parameter int CNT_W = 16
);
    logic       en;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegisterW;
    logic       MemoryW;
    logic       NoWrite;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic [3:0] Flags;
`ifdef COND_SKIP_CNT_EN
    logic [CNT_W-1:0] SkipCnt;
`endif

    modport master (
        output en, Cond, ALUFlags, FlagW, PCS, RegisterW, MemoryW, NoWrite,
        input  PCSrc, RegWrite, MemWrite, CondEx, Flags
`ifdef COND_SKIP_CNT_EN
        , input SkipCnt
`endif
    );

    modport slave (
        input  en, Cond, ALUFlags, FlagW, PCS, RegisterW, MemoryW, NoWrite,
        output PCSrc, RegWrite, MemWrite, CondEx, Flags
`ifdef COND_SKIP_CNT_EN
        , output SkipCnt
`endif
    );

endinterface

// File: rtl/cond_logic_unit_cond_check.sv
// Combinational ARM condition evaluation of a 4-bit Cond field against NZCV; zero latency.
// Encoding 1111 is treated as always.
module cond_check
    import cpu_cond_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n, z, c, v;

    assign n = Flags[FLAG_N];
    assign z = Flags[FLAG_Z];
    assign c = Flags[FLAG_C];
    assign v = Flags[FLAG_V];

    always_comb begin
        CondEx = 1'b1;
        case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = ~z & (n == v);
            COND_LE: CondEx = z | (n != v);
            default: CondEx = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_logic_unit.sv
// NZCV register plus condition gating of PCS/RegisterW/MemoryW; strobes are zero-latency, flags update on the edge.
// No backpressure; COND_SKIP_CNT_EN adds a saturating count of squashed strobing instructions.
module cond_logic_unit
    import cpu_cond_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    cond_logic_unit_if.slave bus
);

    logic [3:0] flags_q;
    logic       cond_pass;
    logic       cond_ex;

    cond_check u_cond_check (
        .Cond   (bus.Cond),
        .Flags  (flags_q),
        .CondEx (cond_pass)
    );

    // Reset masks the condition so no strobe escapes while flags are being forced.
    assign cond_ex      = cond_pass & ~reset;
    assign bus.CondEx   = cond_ex;
    assign bus.PCSrc    = bus.PCS & cond_ex;
    assign bus.RegWrite = bus.RegisterW & cond_ex & ~bus.NoWrite;
    assign bus.MemWrite = bus.MemoryW & cond_ex;
    assign bus.Flags    = flags_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= RESET_FLAGS;
        end else if (bus.en && cond_ex) begin
            if (bus.FlagW[FW_NZ]) begin
                flags_q[FLAG_N] <= bus.ALUFlags[FLAG_N];
                flags_q[FLAG_Z] <= bus.ALUFlags[FLAG_Z];
            end
            if (bus.FlagW[FW_CV]) begin
                flags_q[FLAG_C] <= bus.ALUFlags[FLAG_C];
                flags_q[FLAG_V] <= bus.ALUFlags[FLAG_V];
            end
        end
    end

`ifdef COND_SKIP_CNT_EN
    logic [CNT_W-1:0] skip_q;
    logic             skip_evt;

    assign skip_evt    = bus.en & ~cond_ex & (bus.PCS | bus.RegisterW | bus.MemoryW);
    assign bus.SkipCnt = skip_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skip_q <= '0;
        end else if (skip_evt && !(&skip_q)) begin
            skip_q <= skip_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
`endif

endmodule
